uart_program_loader: RTL and testbench

// - Receives a CPU program over uart_rx (8N1, LSB first) and writes it word by word into the instruction BSRAM.
// - Sits upstream of the BSRAM port mux and replaces the fixed boot table as the source of program words.
// - Holds the CPU off (cpu_hold) while a load is in progress. Reports success/failure on status flags.

---
 rtl/uart_program_loader.sv | 191 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Serial program loader: receives 0xA5, length, 16-bit words and checksum over an 8N1
// UART and streams the words into the instruction BSRAM while holding the CPU in reset.
module uart_program_loader #(
    parameter int CLK_HZ  = 27_000_000,
    parameter int BAUD    = 115_200,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = CLK_HZ / 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_ok,
    output logic              load_err
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, DONE, ERR} state_t;

    rx_state_t        rx_state;
    logic             rx_m, rx_s, rx_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             byte_vld, frame_err;
    logic [7:0]       rx_byte;

    assign rx_byte = shreg;

    // Receiver: a start bit is confirmed at mid-bit, data and stop sampled one bit apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= R_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= uart_rx;
            rx_s      <= rx_m;
            rx_prev   <= rx_s;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_s) rx_state <= R_START;
                end
                R_START: begin
                    if (bit_cnt == CNT_W'(HALF - 1)) begin
                        bit_cnt  <= '0;
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bit_cnt == CNT_W'(CPB - 1)) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= R_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (bit_cnt == CNT_W'(CPB - 1)) begin
                        bit_cnt   <= '0;
                        rx_state  <= R_IDLE;
                        byte_vld  <= rx_s;
                        frame_err <= !rx_s;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    state_t          state;
    logic [7:0]      len_h, hi, sum;
    logic [LEN_W-1:0] len, index, index_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     n16;
    logic            in_frame, timed_out;

    assign index_nxt = index + LEN_W'(1);
    assign n16       = {len_h, rx_byte};
    assign in_frame  = (state == LEN_H) || (state == LEN_L) || (state == DATA_H) ||
                       (state == DATA_L) || (state == CSUM);
    assign timed_out = in_frame && !byte_vld && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_h     <= '0;
            hi        <= '0;
            sum       <= '0;
            len       <= '0;
            index     <= '0;
            to_cnt    <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            to_cnt    <= (!in_frame || byte_vld) ? '0 : to_cnt + 1'b1;
            if ((in_frame && frame_err) || timed_out) begin
                state    <= ERR;
                load_err <= 1'b1;
                cpu_hold <= 1'b0;
            end else if (byte_vld) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (rx_byte == SYNC) begin
                            state    <= LEN_H;
                            cpu_hold <= 1'b1;
                            load_ok  <= 1'b0;
                            load_err <= 1'b0;
                        end
                    end
                    LEN_H: begin
                        len_h <= rx_byte;
                        state <= LEN_L;
                    end
                    LEN_L: begin
                        if (n16 == 16'd0 || {1'b0, n16} > MAX_N) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            len   <= LEN_W'(n16);
                            index <= '0;
                            sum   <= '0;
                            state <= DATA_H;
                        end
                    end
                    DATA_H: begin
                        hi    <= rx_byte;
                        sum   <= sum + rx_byte;
                        state <= DATA_L;
                    end
                    DATA_L: begin
                        // Registered, so the strobe lands one cycle after the low byte.
                        mem_we   <= 1'b1;
                        mem_din  <= {hi, rx_byte};
                        mem_addr <= index[ADDR_W-1:0];
                        index    <= index_nxt;
                        sum      <= sum + rx_byte;
                        state    <= (index_nxt == len) ? CSUM : DATA_H;
                    end
                    CSUM: begin
                        cpu_hold <= 1'b0;
                        if (rx_byte == sum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            load_ok   <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table of whole frames plus hand-written corner sequences,
// written words checked against an expected-write queue.
module tb_uart_program_loader;
    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              uart_rx;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_we, cpu_hold, load_done, load_ok, load_err;

    uart_program_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .cpu_hold(cpu_hold), .load_done(load_done), .load_ok(load_ok),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_din});
        if (load_done) done_cnt++;
    end

    typedef struct {
        logic [95:0] bytes;
        int          nbytes;
        logic        exp_ok;
        logic        exp_err;
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    function automatic logic [7:0] byte_at(input logic [95:0] bytes, input int i);
        return bytes[95 - 8 * i -: 8];
    endfunction

    // Expected writes: words after the first sync byte, as long as the length is legal.
    task automatic push_expected(input logic [95:0] bytes, input int nb);
        int s;
        int n;
        s = -1;
        for (int i = 0; i < nb; i++)
            if (s < 0 && byte_at(bytes, i) == 8'hA5) s = i;
        if (s >= 0 && s + 2 < nb) begin
            n = {byte_at(bytes, s + 1), byte_at(bytes, s + 2)};
            if (n >= 1 && n <= (1 << ADDR_W))
                for (int w = 0; w < n; w++)
                    if (s + 4 + 2 * w < nb)
                        exp_q.push_back({4'(w), byte_at(bytes, s + 3 + 2 * w),
                                         byte_at(bytes, s + 4 + 2 * w)});
        end
    endtask

    task automatic compare_writes(input string name);
        logic [19:0] e;
        logic [19:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s missing write: got none expected %h", name, e);
            end else begin
                g = got_q.pop_front();
                check({name, " write"}, 32'(g), 32'(e));
            end
        end
        check({name, " extra writes"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    task automatic check_flags(input string name, input logic ok, input logic err, input logic hold);
        check({name, " load_ok"}, 32'(load_ok), 32'(ok));
        check({name, " load_err"}, 32'(load_err), 32'(err));
        check({name, " cpu_hold"}, 32'(cpu_hold), 32'(hold));
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
    endtask

    initial begin
        int d0;
        logic [7:0] s8;
        logic [7:0] hb;
        logic [7:0] lb;

        vecs[0] = '{96'hA5_00_02_00_A1_00_78_19_00_00_00_00, 8, 1'b1, 1'b0, 1};
        vecs[1] = '{96'hA5_00_02_00_A1_00_78_18_00_00_00_00, 8, 1'b0, 1'b1, 0};
        vecs[2] = '{96'h3C_5A_A5_00_01_12_34_46_00_00_00_00, 8, 1'b1, 1'b0, 1};
        vecs[3] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 3, 1'b0, 1'b1, 0};
        vecs[4] = '{96'hA5_00_11_00_00_00_00_00_00_00_00_00, 3, 1'b0, 1'b1, 0};
        vecs[5] = '{96'hA5_00_01_A5_A5_4A_00_00_00_00_00_00, 6, 1'b1, 1'b0, 1};
        vecs[6] = '{96'hA5_00_02_FF_FF_80_01_7F_00_00_00_00, 8, 1'b1, 1'b0, 1};

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_din", 32'(mem_din), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        glitch();
        check_flags("idle glitch", 1'b0, 1'b0, 1'b0);
        compare_writes("idle glitch");

        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt;
            push_expected(vecs[v].bytes, vecs[v].nbytes);
            for (int i = 0; i < vecs[v].nbytes; i++) send_byte(byte_at(vecs[v].bytes, i), 1'b1);
            repeat (5) @(negedge clk);
            check_flags($sformatf("vec%0d", v), vecs[v].exp_ok, vecs[v].exp_err, 1'b0);
            check($sformatf("vec%0d load_done count", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            compare_writes($sformatf("vec%0d", v));
        end

        // Glitch between data bytes must not disturb the frame.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        check_flags("mid-frame hold", 1'b0, 1'b0, 1'b1);
        glitch();
        exp_q.push_back({4'd0, 16'h1234});
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h46, 1'b1);
        check_flags("data glitch", 1'b1, 1'b0, 1'b0);
        compare_writes("data glitch");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b0);
        check_flags("stop bit error", 1'b0, 1'b1, 1'b0);
        compare_writes("stop bit error");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (TIMEOUT / 2) @(negedge clk);
        check_flags("before timeout", 1'b0, 1'b0, 1'b1);
        repeat (TIMEOUT) @(negedge clk);
        check_flags("after timeout", 1'b0, 1'b1, 1'b0);
        compare_writes("timeout");

        // Largest legal length fills the whole memory.
        d0 = done_cnt;
        s8 = 8'h00;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int w = 0; w < 16; w++) begin
            hb = 8'(w * 17 + 3);
            lb = 8'($urandom_range(0, 255));
            s8 = s8 + hb + lb;
            exp_q.push_back({4'(w), hb, lb});
            send_byte(hb, 1'b1);
            send_byte(lb, 1'b1);
        end
        send_byte(s8, 1'b1);
        repeat (5) @(negedge clk);
        check_flags("full memory", 1'b1, 1'b0, 1'b0);
        check("full memory load_done count", 32'(done_cnt - d0), 32'd1);
        compare_writes("full memory");

        // Reset while the low data byte is on the wire.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_flags("mid-frame reset", 1'b0, 1'b0, 1'b0);
        check("mid-frame reset mem_we", 32'(mem_we), 32'd0);
        check("mid-frame reset mem_addr", 32'(mem_addr), 32'd0);
        check("mid-frame reset mem_din", 32'(mem_din), 32'd0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        compare_writes("mid-frame reset");

        d0 = done_cnt;
        push_expected(vecs[0].bytes, vecs[0].nbytes);
        for (int i = 0; i < vecs[0].nbytes; i++) send_byte(byte_at(vecs[0].bytes, i), 1'b1);
        repeat (5) @(negedge clk);
        check_flags("after reset", 1'b1, 1'b0, 1'b0);
        check("after reset load_done count", 32'(done_cnt - d0), 32'd1);
        compare_writes("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
